// File: rtl/uart_encoder_pkg.sv
// Shared state encoding and line constants for the UART encoder.
// Macro UART_ENCODER_PARITY_EN adds the PARITY state to the enum.
package uart_encoder_pkg;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_ENCODER_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_encoder_fifo.sv
// First-word-fall-through byte FIFO with wrapping pointers and an occupancy count.
module uart_encoder_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop frees the slot in the same edge, so a full FIFO may still take a push then.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_encoder.sv
// UART transmitter: byte FIFO feeding a serializer with a down-counting baud timer.
// Macro UART_ENCODER_PARITY_EN inserts an even-parity bit after the data bits.
//   state  | meaning
//   IDLE   | line high, waiting for a queued byte
//   START  | start bit (0)
//   DATA   | 8 data bits, LSB first
//   PARITY | even parity of the data byte (parity builds only)
//   STOP   | STOP_BITS stop bits (1)
module uart_encoder
  import uart_encoder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          uart_tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam logic [15:0] CNT_LOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_line_active;
  logic        w_tx_nxt;
  logic        w_pop;
  logic        w_bit_done;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_head;
`ifdef UART_ENCODER_PARITY_EN
  logic        r_parity;
`endif

  uart_encoder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (valid_i && ready_o),
    .i_data  (data_i),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (level_o)
  );

  assign ready_o    = !w_fifo_full;
  assign uart_tx_o  = r_tx;
  assign w_bit_done = (r_cnt == '0);
  // The line lags the state by one register, so cover that trailing cycle too.
  assign busy_o     = (r_state != IDLE) || !w_fifo_empty || r_line_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = UART_IDLE_LEVEL;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_done) w_state_nxt = DATA;
      end
      DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_done && (r_bit_idx == LAST_DATA)) begin
`ifdef UART_ENCODER_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef UART_ENCODER_PARITY_EN
      PARITY: begin
        w_tx_nxt = r_parity;
        if (w_bit_done) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        if (w_bit_done && (r_bit_idx == LAST_STOP)) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_tx          <= UART_IDLE_LEVEL;
      r_line_active <= 1'b0;
`ifdef UART_ENCODER_PARITY_EN
      r_parity      <= 1'b0;
`endif
    end else begin
      r_tx          <= w_tx_nxt;
      r_line_active <= (r_state != IDLE);

      if (w_state_nxt == IDLE)     r_cnt <= '0;
      else if (w_pop || w_bit_done) r_cnt <= CNT_LOAD;
      else                          r_cnt <= r_cnt - 1'b1;

      if (w_state_nxt != r_state) r_bit_idx <= '0;
      else if (w_bit_done)        r_bit_idx <= r_bit_idx + 1'b1;

      if (w_pop) begin
        r_shift  <= w_head;
`ifdef UART_ENCODER_PARITY_EN
        r_parity <= ^w_head;
`endif
      end else if ((r_state == DATA) && w_bit_done) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

endmodule

// File: doc/uart_encoder.md
UART_ENCODER -- requirements
Module: uart_encoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the byte FIFO depth; power of two, 2..256.
REQ-003 SHALL have parameter STOP_BITS, default 1, giving stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port data_i, input, 8, the byte to transmit.
REQ-007 SHALL have port valid_i, input, 1, marking data_i valid.
REQ-008 SHALL have port ready_o, output, 1, high when the FIFO can accept a byte.
REQ-009 SHALL have port uart_tx_o, output, 1, the serial line that drives the DUT receive pad; idle high.
REQ-010 SHALL have port busy_o, output, 1, high while a frame is on the line or the FIFO is non-empty.
REQ-011 SHALL have port level_o, output, clog2(FIFO_DEPTH)+1, the FIFO occupancy.

Function
REQ-012 SHALL accept a byte on the rising clk edge where valid_i and ready_o are both high; ready_o SHALL equal (level_o != FIFO_DEPTH).
REQ-013 SHALL ignore data_i whenever ready_o is low; no overwrite, no error flag.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; frame order is start(0), 8 data bits LSB first, optional parity, STOP_BITS stop bits(1).
REQ-015 SHALL leave IDLE when the FIFO is non-empty: pop the head and drive uart_tx_o low on the next edge.
REQ-016 SHALL hold every bit for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary; uart_tx_o SHALL be registered (glitch-free).
REQ-017 SHALL start the first frame with uart_tx_o falling exactly 2 clk edges after the accepting edge when idle with an empty FIFO.
REQ-018 SHALL, at the end of the last stop bit with the FIFO non-empty, go directly to START with no idle gap; otherwise it SHALL go to IDLE.
REQ-019 SHALL, on a simultaneous push and pop, keep level_o unchanged, including when the FIFO is full.
REQ-020 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH; level_o SHALL saturate at neither 0 nor FIFO_DEPTH by construction.

Reset
REQ-021 SHALL, when rst_n is asserted, immediately set: uart_tx_o=1, ready_o=1, busy_o=0, level_o=0, state=IDLE, counters=0, FIFO emptied.
REQ-022 SHALL truncate any frame in progress at reset (line high at once); no partial byte is resumed after reset.

Configuration
REQ-023 SHALL, with macro UART_ENCODER_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) in state PARITY between data and stop.
REQ-024 SHALL, without UART_ENCODER_PARITY_EN, omit state PARITY entirely; frame is 9+STOP_BITS bits long.

Structure
REQ-025 SHALL take the state enum, UART_IDLE_LEVEL=1 and UART_DATA_BITS=8 from shared package uart_encoder_pkg.
REQ-026 SHALL implement the FIFO as sub-module uart_encoder_fifo (first-word-fall-through, synchronous push/pop, level output); serializer and baud counter stay in uart_encoder.

Verification
REQ-027 SHALL be covered: CLKS_PER_BIT=4, parity off, push 0x55 -> uart_tx_o = 0,1,0,1,0,1,0,1,0,1 each held 4 cycles, falling 2 edges after accept, then high.
REQ-028 SHALL be covered: UART_ENCODER_PARITY_EN, push 0x07 -> parity bit 1; push 0x03 -> parity bit 0; frame length 11 bits.
REQ-029 SHALL be covered: push 17 bytes back-to-back with line busy -> ready_o low after 16 queued, 17th ignored, level_o=16.
REQ-030 SHALL be covered: push 0xA0 and 0x0F back-to-back -> second start bit begins on the cycle after the first stop bit ends, no idle bit.
REQ-031 SHALL be covered: assert rst_n low mid DATA of 0xFF -> uart_tx_o high in the same cycle, level_o=0; after release, idle line, new push sends correctly.
REQ-032 SHALL be covered: loop uart_tx_o into uart_decoder with CLKS_PER_BIT=434 at 50 MHz -> decoder prints bytes 0x48,0x69 ("Hi") in order.
